// File: rtl/corral_pkg.sv
// Shared types and glyph constants for the corral position display.
// The optional RESULT blink is enabled by defining CORRAL_DISPLAY_BLINK_EN.
package corral_pkg;

   typedef enum logic [2:0] {
      SHOW_COWBOY,
      GAP_A,
      SHOW_HORSE,
      GAP_B,
      RESULT
   } disp_state_e;

   // Segment bit order within a 7-bit glyph: {g,f,e,d,c,b,a}
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam int CNT_W = 16;

   localparam logic [6:0] BLANK      = 7'b0000000;
   localparam logic [6:0] GLYPH_WON  = 7'b0111110;
   localparam logic [6:0] GLYPH_LOST = 7'b0111000;

   // Entry n sits at [n]; F is written first because it is the MSB slot.
   localparam logic [15:0][6:0] HEX_GLYPH = {
      7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
      7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
      7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
      7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to 7-segment glyph lookup.
// Output bit order is {g,f,e,d,c,b,a}, active-high.
import corral_pkg::*;

module seg7_decode (
   input  logic [3:0] value,
   output logic [6:0] seg
);

   always_comb begin
      seg = HEX_GLYPH[value];
   end

endmodule

// File: rtl/corral_display.sv
// Multiplexed cowboy/horse position display with game result glyph.
// Define CORRAL_DISPLAY_BLINK_EN to blink the result glyph.
import corral_pkg::*;

module corral_display #(
   parameter int DWELL_CYCLES = 1000,
   parameter int GAP_CYCLES   = 250,
   parameter int BLINK_CYCLES = 500
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] cowboypos,
   input  logic [3:0] horsepos,
   input  logic       gameover,
   input  logic       lostwon,
   input  logic       ready,
   output logic [6:0] seg,
   output logic       dp
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

   if (DWELL_CYCLES < 2 || DWELL_CYCLES > 65535) begin : g_bad_dwell
      $error("DWELL_CYCLES out of range");
   end
   if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_gap
      $error("GAP_CYCLES out of range");
   end
   if (BLINK_CYCLES < 1 || BLINK_CYCLES > 65535) begin : g_bad_blink
      $error("BLINK_CYCLES out of range");
   end

   disp_state_e      state_q, state_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic [3:0]       cow_q, cow_d;
   logic [3:0]       horse_q, horse_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       digit;
   logic [6:0]       hex_seg;
   logic             result_vis;

   seg7_decode u_dec (
      .value (digit),
      .seg   (hex_seg)
   );

   assign digit = (state_q == SHOW_HORSE) ? horse_q : cow_q;

   always_comb begin
      cow_d   = ready ? cowboypos : cow_q;
      horse_d = ready ? horsepos  : horse_q;
      state_d = state_q;
      phase_d = phase_q + 1'b1;
      case (state_q)
         SHOW_COWBOY: if (phase_q == DWELL_LAST) begin
            state_d = GAP_A;
            phase_d = '0;
         end
         GAP_A: if (phase_q == GAP_LAST) begin
            state_d = SHOW_HORSE;
            phase_d = '0;
         end
         SHOW_HORSE: if (phase_q == DWELL_LAST) begin
            state_d = GAP_B;
            phase_d = '0;
         end
         GAP_B: if (phase_q == GAP_LAST) begin
            state_d = SHOW_COWBOY;
            phase_d = '0;
         end
         default: begin
            state_d = SHOW_COWBOY;
            phase_d = '0;
         end
      endcase
      // Game end wins over any dwell/gap advance in the same cycle
      if (gameover) begin
         state_d = RESULT;
         phase_d = '0;
      end
   end

`ifdef CORRAL_DISPLAY_BLINK_EN
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_vis_q, blink_vis_d;

   always_comb begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      blink_vis_d = blink_vis_q;
      if (state_q != RESULT) begin
         blink_cnt_d = '0;
         blink_vis_d = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_vis_d = ~blink_vis_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt_q <= '0;
         blink_vis_q <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_vis_q <= blink_vis_d;
      end
   end

   assign result_vis = blink_vis_q;
`else
   assign result_vis = 1'b1;
`endif

   always_comb begin
      seg_d = BLANK;
      dp_d  = 1'b0;
      case (state_q)
         SHOW_COWBOY: seg_d = hex_seg;
         SHOW_HORSE: begin
            seg_d = hex_seg;
            dp_d  = 1'b1;
         end
         RESULT: if (result_vis) begin
            seg_d = lostwon ? GLYPH_WON : GLYPH_LOST;
         end
         default: seg_d = BLANK;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SHOW_COWBOY;
         phase_q <= '0;
         cow_q   <= '0;
         horse_q <= '0;
         seg_q   <= BLANK;
         dp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cow_q   <= cow_d;
         horse_q <= horse_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_corral_display.sv
// Self-checking bench for corral_display with a cycle-level reference model.
// Honours CORRAL_DISPLAY_BLINK_EN the same way as the design.
module tb_corral_display;

   localparam int D = 4;
   localparam int G = 2;
   localparam int B = 3;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic [3:0] cowboypos = '0;
   logic [3:0] horsepos = '0;
   logic       gameover = 1'b0;
   logic       lostwon = 1'b0;
   logic       ready = 1'b0;
   logic [6:0] seg;
   logic       dp;

   int checks = 0;
   int errors = 0;

   logic [6:0] hex_tab [16];
   int         m_st;
   int         m_age;
   logic [3:0] m_cow;
   logic [3:0] m_horse;
   logic [6:0] exp_seg;
   logic       exp_dp;

   typedef struct {
      logic [3:0] cow;
      logic [3:0] horse;
      logic [6:0] ec;
      logic [6:0] eh;
   } vec_t;
   vec_t vt [8];

   corral_display #(
      .DWELL_CYCLES (D),
      .GAP_CYCLES   (G),
      .BLINK_CYCLES (B)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .cowboypos (cowboypos),
      .horsepos  (horsepos),
      .gameover  (gameover),
      .lostwon   (lostwon),
      .ready     (ready),
      .seg       (seg),
      .dp        (dp)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic check7(input string name, input logic [6:0] act,
                         input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: seg=%b expected %b", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act,
                         input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic int dur(input int st);
      return (st == 0 || st == 2) ? D : G;
   endfunction

   // States: 0 cowboy, 1 gap, 2 horse, 3 gap, 4 result; m_age = cycles in state
   task automatic model_edge();
      logic vis;
      vis = ((m_age / B) % 2) == 0;
`ifndef CORRAL_DISPLAY_BLINK_EN
      vis = 1'b1;
`endif
      case (m_st)
         0: exp_seg = hex_tab[m_cow];
         2: exp_seg = hex_tab[m_horse];
         4: exp_seg = vis ? (lostwon ? 7'b0111110 : 7'b0111000) : 7'b0;
         default: exp_seg = 7'b0;
      endcase
      exp_dp = (m_st == 2);
      if (ready) begin
         m_cow   = cowboypos;
         m_horse = horsepos;
      end
      if (gameover) begin
         if (m_st != 4) begin
            m_st  = 4;
            m_age = 0;
         end else begin
            m_age++;
         end
      end else if (m_st == 4) begin
         m_st  = 0;
         m_age = 0;
      end else if (m_age == dur(m_st) - 1) begin
         m_st  = (m_st + 1) % 4;
         m_age = 0;
      end else begin
         m_age++;
      end
   endtask

   task automatic model_reset();
      m_st    = 0;
      m_age   = 0;
      m_cow   = '0;
      m_horse = '0;
   endtask

   task automatic cyc(input string name);
      @(posedge clock);
      model_edge();
      #1;
      check7({name, ".seg"}, seg, exp_seg);
      check1({name, ".dp"}, dp, exp_dp);
   endtask

   task automatic run(input int n, input string name);
      for (int i = 0; i < n; i++) cyc(name);
   endtask

   task automatic wait_state(input int st, input int age,
                             input string name);
      bit found;
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (m_st == st && m_age == age) found = 1;
         else cyc(name);
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s: state %0d/%0d not reached", name, st, age);
      end
   endtask

   task automatic do_reset(input string name);
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check7({name, ".rst_seg"}, seg, 7'b0);
      check1({name, ".rst_dp"}, dp, 1'b0);
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      vt[0] = '{4'h0, 4'h8, 7'h3F, 7'h7F};
      vt[1] = '{4'h1, 4'h9, 7'h06, 7'h6F};
      vt[2] = '{4'h2, 4'hA, 7'h5B, 7'h77};
      vt[3] = '{4'h4, 4'hB, 7'h66, 7'h7C};
      vt[4] = '{4'h5, 4'hD, 7'h6D, 7'h5E};
      vt[5] = '{4'h6, 4'hE, 7'h7D, 7'h79};
      vt[6] = '{4'h7, 4'hF, 7'h07, 7'h71};
      vt[7] = '{4'h3, 4'hC, 7'h4F, 7'h39};

      model_reset();
      #2;
      reset_n = 1'b0;
      #1;
      check7("reset.seg", seg, 7'b0);
      check1("reset.dp", dp, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         do_reset("vec");
         ready = 1'b1;
         cowboypos = vt[i].cow;
         horsepos = vt[i].horse;
         cyc("vec_first");
         cyc("vec_cow");
         check7("vec_cow_tab", seg, vt[i].ec);
         check1("vec_cow_dp", dp, 1'b0);
         run(4, "vec_mid");
         cyc("vec_horse");
         check7("vec_horse_tab", seg, vt[i].eh);
         check1("vec_horse_dp", dp, 1'b1);
         run(3, "vec_tail");
      end

      run(12, "cycle32");

      ready = 1'b0;
      cowboypos = 4'd7;
      run(3, "hold");
      wait_state(0, 1, "hold_wait");
      check7("hold_snapshot", seg, 7'h4F);
      ready = 1'b1;
      cyc("load1");
      ready = 1'b0;
      wait_state(0, 1, "load_wait");
      check7("loaded_7", seg, 7'h07);

      wait_state(2, 1, "horse2");
      gameover = 1'b1;
      lostwon = 1'b1;
      cyc("go_enter");
      cyc("go_first");
      check7("won_glyph", seg, 7'b0111110);
      check1("won_dp", dp, 1'b0);
      run(10, "result");
      lostwon = 1'b0;
      run(7, "lost");
      gameover = 1'b0;
      run(14, "resume");

      wait_state(0, D - 1, "edge_race");
      gameover = 1'b1;
      cyc("race_enter");
      cyc("race_first");
      check7("race_no_gap", seg, 7'b0111000);
      gameover = 1'b0;
      run(4, "race_exit");

      ready = 1'b1;
      wait_state(3, 1, "gapb");
      #3;
      reset_n = 1'b0;
      #1;
      check7("mid_rst_seg", seg, 7'b0);
      check1("mid_rst_dp", dp, 1'b0);
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      cyc("post_rst");
      check7("post_rst_zero", seg, 7'h3F);
      run(8, "post_rst_dwell");

      for (int i = 0; i < 500; i++) begin
         ready = 1'($urandom % 2);
         cowboypos = 4'($urandom);
         horsepos = 4'($urandom);
         lostwon = 1'($urandom % 2);
         if ($urandom % 12 == 0) gameover = ~gameover;
         cyc("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
